// File: rtl/spi_pkg.sv
// spi_pkg: shared state encodings and SCLK edge-level helpers
// for the SPI master and its clock divider.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        XFER  = 2'b11,
        DONE  = 2'b10
    } spi_state_e;

    // SCLK level reached by a leading edge (CPHA=0: sample edge).
    function automatic logic lead_level(input logic cpol);
        return ~cpol;
    endfunction

    // SCLK level reached by a trailing edge (CPHA=0: shift edge).
    function automatic logic trail_level(input logic cpol);
        return cpol;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI master.
// Ports: clk/rst, en_i enables counting (cleared when low),
// tick_o pulses one cycle every p_clk_div enabled cycles.
module spi_clk_div #(
    parameter int p_clk_div = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(p_clk_div + 1);
    localparam logic [CW-1:0] LAST = CW'(p_clk_div - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master.sv
// spi_master: single-frame SPI master, CPHA=0, configurable CPOL,
// variable frame length up to p_data_buffer_length bits, MSB first.
// Ports: clk/rst; ip_data_out/ip_data_count/i_start request a frame;
// op_data_in/o_data_valid return it; o_busy, o_sclk, o_mosi,
// i_miso, o_ce (active-low) form the status and SPI bus.
module spi_master
    import spi_pkg::*;
#(
    parameter int p_data_buffer_length  = 32,
    parameter int p_width_buffer_length = $clog2(p_data_buffer_length) + 1,
    parameter int p_clk_div             = 8,
    parameter int p_cpol                = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [p_data_buffer_length-1:0]  ip_data_out,
    input  logic [p_width_buffer_length-1:0] ip_data_count,
    input  logic                             i_start,
    output logic [p_data_buffer_length-1:0]  op_data_in,
    output logic                             o_data_valid,
    output logic                             o_busy,
    output logic                             o_sclk,
    output logic                             o_mosi,
    input  logic                             i_miso,
    output logic                             o_ce
);

    localparam int W  = p_data_buffer_length;
    localparam int WB = p_width_buffer_length;
    localparam logic CPOL = (p_cpol != 0);

    spi_state_e state_q, state_d;

    logic [WB-1:0] count_q, count_d;
    logic [WB:0]   edge_q, edge_d;
    logic [W-1:0]  tx_q, tx_d;
    logic [W-1:0]  rx_q, rx_d;
    logic [W-1:0]  data_in_q, data_in_d;
    logic          sclk_q, sclk_d;

    logic          tick;
    logic          div_en;
    logic          accept;
    logic [WB-1:0] cnt_clamp;
    logic [WB-1:0] tx_shift;
    logic [WB:0]   edges_total;
    logic          xfer_end;
    logic          edge_ev;
    logic          lead_ev;
    logic          trail_ev;
    logic          last_trail;

    assign div_en = (state_q == SETUP) || (state_q == XFER);

    spi_clk_div #(
        .p_clk_div(p_clk_div)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .en_i  (div_en),
        .tick_o(tick)
    );

    assign accept = (state_q == IDLE) && i_start
                 && (ip_data_count != '0);

    assign cnt_clamp = (ip_data_count > WB'(W)) ? WB'(W)
                                                : ip_data_count;

    // Left-justify the frame so the first bit out is always tx_q[W-1].
    assign tx_shift = WB'(W) - cnt_clamp;

    assign edges_total = {count_q, 1'b0};
    assign xfer_end    = (state_q == XFER) && (edge_q == edges_total);

    // The first leading edge is produced as SETUP ends.
    assign edge_ev = tick && ((state_q == SETUP)
                   || ((state_q == XFER) && (edge_q != edges_total)));

    // Even edge index = leading edge, odd = trailing edge.
    assign lead_ev    = edge_ev && !edge_q[0];
    assign trail_ev   = edge_ev && edge_q[0];
    assign last_trail = (edge_q == edges_total - (WB+1)'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept)   state_d = SETUP;
            SETUP: if (tick)     state_d = XFER;
            XFER:  if (xfer_end) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy       = (state_q != IDLE);
        o_data_valid = (state_q == DONE);
        o_ce         = !div_en;
        o_mosi       = div_en ? tx_q[W-1] : 1'b0;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        count_d   = count_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_in_d = data_in_q;
        sclk_d    = sclk_q;

        if (accept) begin
            count_d = cnt_clamp;
            edge_d  = '0;
            tx_d    = ip_data_out << tx_shift;
            rx_d    = '0;
            sclk_d  = CPOL;
        end

        if (edge_ev) begin
            edge_d = edge_q + 1'b1;
            sclk_d = lead_ev ? lead_level(CPOL) : trail_level(CPOL);
        end

        if (lead_ev) begin
            rx_d = {rx_q[W-2:0], i_miso};
        end

        if (trail_ev && !last_trail) begin
            tx_d = tx_q << 1;
        end

        if (xfer_end) begin
            data_in_d = rx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_in_q <= '0;
            sclk_q    <= CPOL;
        end else begin
            count_q   <= count_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_in_q <= data_in_d;
            sclk_q    <= sclk_d;
        end
    end

    assign op_data_in = data_in_q;
    assign o_sclk     = sclk_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized frames against a behavioural SPI slave
// model, plus clamp, zero-count, back-to-back, reset and CPOL=1 cases.
module tb_spi_master;

    localparam int W   = 32;
    localparam int WB  = 6;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data_o = '0;
    logic [WB-1:0] cnt = '0;
    logic          start = 1'b0;
    logic [W-1:0]  data_in;
    logic          valid, busy, sclk, mosi, ce;
    logic          loop = 1'b0;
    logic          slv_bit = 1'b0;
    logic          miso;

    logic [W-1:0]  data1 = '0;
    logic [WB-1:0] cnt1 = '0;
    logic          start1 = 1'b0;
    logic [W-1:0]  data_in1;
    logic          valid1, busy1, sclk1, mosi1, ce1;
    logic          miso1 = 1'b1;

    int total = 0;
    int bad   = 0;

    assign miso = loop ? mosi : slv_bit;

    always #5 clk = ~clk;

    spi_master #(
        .p_data_buffer_length(W),
        .p_clk_div(DIV),
        .p_cpol(0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ip_data_out  (data_o),
        .ip_data_count(cnt),
        .i_start      (start),
        .op_data_in   (data_in),
        .o_data_valid (valid),
        .o_busy       (busy),
        .o_sclk       (sclk),
        .o_mosi       (mosi),
        .i_miso       (miso),
        .o_ce         (ce)
    );

    spi_master #(
        .p_data_buffer_length(W),
        .p_clk_div(2),
        .p_cpol(1)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .ip_data_out  (data1),
        .ip_data_count(cnt1),
        .i_start      (start1),
        .op_data_in   (data_in1),
        .o_data_valid (valid1),
        .o_busy       (busy1),
        .o_sclk       (sclk1),
        .o_mosi       (mosi1),
        .i_miso       (miso1),
        .o_ce         (ce1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One frame; the reference is the frame definition itself:
    // n clamped bits out MSB first, n bits in, 2n edges, valid in
    // cycle t+2+2*n*DIV where cycle t+1 follows the accepting edge t.
    task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] sv,
                             input int req, input bit lp, input bit poke);
        int n, edges, vk, vcnt, sidx;
        logic [W-1:0] mask, mgot, exp_rx;
        logic prev;
        n = (req > W) ? W : req;
        mask = '0;
        for (int i = 0; i < n; i++) mask[i] = 1'b1;
        exp_rx = (lp ? tx : sv) & mask;
        loop = lp;
        @(negedge clk);
        data_o  = tx;
        cnt     = WB'(req);
        start   = 1'b1;
        sidx    = n - 1;
        slv_bit = sv[sidx];
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ce_low", ce, 0);
        chk("busy_hi", busy, 1);
        chk("mosi_first", mosi, tx[n-1]);
        chk("sclk_start", sclk, 0);
        prev = sclk;
        edges = 0;
        vk = -1;
        vcnt = 0;
        mgot = '0;
        for (int k = 1; k <= 2 * n * DIV + 10; k++) begin
            @(posedge clk);
            #1;
            start = poke && (k == 3 * DIV);
            if (sclk !== prev) begin
                edges++;
                if (sclk) begin
                    mgot = {mgot[W-2:0], mosi};
                end else if (sidx > 0) begin
                    sidx--;
                    slv_bit = sv[sidx];
                end
                prev = sclk;
            end
            if (valid) begin
                vcnt++;
                if (vk < 0) begin
                    vk = k;
                    chk("ce_at_valid", ce, 1);
                    chk("rx_data", data_in, exp_rx);
                end
            end
        end
        start = 1'b0;
        chk("edges", edges, 2 * n);
        chk("valid_cycle", vk + 1, 2 + 2 * n * DIV);
        chk("valid_pulses", vcnt, 1);
        chk("mosi_bits", mgot, tx & mask);
        chk("rx_hold", data_in, exp_rx);
        chk("idle_busy", busy, 0);
        chk("idle_mosi", mosi, 0);
        chk("idle_sclk", sclk, 0);
    endtask

    initial begin
        int b, v, e, n, v1, v2, idle;
        logic prev;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce", ce, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data_in, 0);
        chk("rst_sclk1", sclk1, 1);
        rst = 1'b0;

        run_frame(32'h0000_00A5, 32'h0, 8, 1'b1, 1'b0);
        run_frame(32'hDEAD_BEEF, 32'h1234_5678, 32, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 32));
            run_frame($urandom, $urandom, n, 1'($urandom % 2),
                      (n >= 4) && ($urandom % 2 == 1));
        end

        run_frame($urandom, $urandom, 40, 1'b0, 1'b0);
        run_frame($urandom, $urandom, 20, 1'b1, 1'b1);

        // zero-length request must be ignored
        @(negedge clk);
        cnt = '0;
        start = 1'b1;
        b = 0; v = 0; e = 0;
        prev = sclk;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (busy) b++;
            if (valid) v++;
            if (sclk !== prev) e++;
            prev = sclk;
        end
        start = 1'b0;
        chk("zero_busy", b, 0);
        chk("zero_valid", v, 0);
        chk("zero_edges", e, 0);

        // start held: frames back to back, one idle cycle between
        n = 4;
        loop = 1'b1;
        @(negedge clk);
        data_o = 32'h0000_0009;
        cnt = WB'(n);
        start = 1'b1;
        v1 = -1; v2 = -1; idle = 0;
        for (int k = 0; k < 3 * (2 * n * DIV + 3) + 10; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                if (v1 < 0) v1 = k;
                else if (v2 < 0) v2 = k;
            end
            if (v1 >= 0 && v2 < 0 && !busy) idle++;
        end
        start = 1'b0;
        chk("b2b_gap", v2 - v1, 2 * n * DIV + 3);
        chk("b2b_idle", idle, 1);
        chk("b2b_data", data_in, 32'h9);
        repeat (2 * n * DIV + 10) @(posedge clk);
        #1;
        chk("b2b_end_busy", busy, 0);

        // reset after five edges aborts the frame
        @(negedge clk);
        data_o = 32'h0000_00FF;
        cnt = 8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        prev = sclk;
        for (int k = 0; k < 200 && e < 5; k++) begin
            @(posedge clk);
            #1;
            if (sclk !== prev) e++;
            prev = sclk;
        end
        chk("abort_edges", e, 5);
        rst = 1'b1;
        #1;
        chk("abort_ce", ce, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data_in, 0);
        v = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (valid) v++;
        end
        chk("abort_valid", v, 0);
        rst = 1'b0;
        run_frame(32'h0000_3C5A, 32'h0000_0F0F, 16, 1'b0, 1'b0);

        // CPOL=1 instance, one-bit frame, miso tied high
        chk("cpol1_idle", sclk1, 1);
        @(negedge clk);
        data1 = 32'h0;
        cnt1 = 1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        e = 0; v = 0;
        prev = sclk1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (sclk1 !== prev) e++;
            if (valid1) v++;
            prev = sclk1;
        end
        chk("cpol1_edges", e, 2);
        chk("cpol1_valid", v, 1);
        chk("cpol1_data", data_in1, 1);
        chk("cpol1_end", sclk1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
